// File: rtl/led_matrix_timer_driver.sv
// led_matrix_timer_driver
//
// Programs an Avalon-MM interval timer for LED matrix refresh. It services the
// timer interrupt and counts ticks. A start request writes the period low half,
// the period high half and the control word. The block then waits in RUN. Each
// interrupt is acknowledged by clearing the status register, which also emits
// one tick. A stop request writes STOP to control and clears status.
//
// Optional feature: define TIMER_DRV_READBACK_EN to read the period registers
// back after programming and compare them with the requested period. On a
// mismatch the block raises err (sticky) and aborts without writing control.
//
// Parameters
//   TICK_W      width of tick_count
//   CONTINUOUS  value placed in the control CONT bit (bit 1)
//
// Ports
//   clk, reset                  clock, synchronous active-high reset
//   cfg_period, cfg_start       period and program-and-start pulse
//   cfg_stop                    stop pulse
//   av_address/chipselect/write_n/writedata   Avalon-MM master write side
//   av_readdata                 registered slave data (one-cycle latency)
//   av_irq                      timer interrupt level
//   tick, tick_count            serviced-interrupt pulse and counter
//   busy, running, err          status outputs
module led_matrix_timer_driver #(
    parameter int TICK_W     = 16,
    parameter int CONTINUOUS = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [31:0]       cfg_period,
    input  logic              cfg_start,
    input  logic              cfg_stop,
    output logic [2:0]        av_address,
    output logic              av_chipselect,
    output logic              av_write_n,
    output logic [15:0]       av_writedata,
    input  logic [15:0]       av_readdata,
    input  logic              av_irq,
    output logic              tick,
    output logic [TICK_W-1:0] tick_count,
    output logic              busy,
    output logic              running,
    output logic              err
);

    localparam logic        CONT_BIT  = (CONTINUOUS != 0);
    // Control word bits: [3] STOP, [2] START, [1] CONT, [0] ITO
    localparam logic [15:0] CTRL_RUN  = {12'b0, 1'b0, 1'b1, CONT_BIT, 1'b1};
    localparam logic [15:0] CTRL_STOP = 16'h0008;

    typedef enum logic [3:0] {
        S_IDLE,
        S_WR_PL,
        S_WR_PH,
        S_RD_PL,
        S_RD_PH,
        S_RD_CHK,
        S_WR_CTRL,
        S_RUN,
        S_CLR_STS,
        S_STOP_CTRL,
        S_STOP_STS
    } state_t;

    state_t            state_q, state_d;
    logic [31:0]       period_q, period_d;
    logic              stop_pending_q, stop_pending_d;
    logic [TICK_W-1:0] tick_count_q, tick_count_d;
    logic              in_prog;

`ifdef TIMER_DRV_READBACK_EN
    logic [15:0]       rb_lo_q, rb_lo_d;
    logic              err_q, err_d;
`else
    logic              unused_readdata;
    assign unused_readdata = ^av_readdata;
`endif

    // Programming phase: a stop request here is deferred until RUN is reached
    assign in_prog = (state_q == S_WR_PL) || (state_q == S_WR_PH) ||
                     (state_q == S_RD_PL) || (state_q == S_RD_PH) ||
                     (state_q == S_RD_CHK) || (state_q == S_WR_CTRL);

    always_comb begin
        state_d        = state_q;
        period_d       = period_q;
        stop_pending_d = stop_pending_q;
        tick_count_d   = tick_count_q;
        av_address     = 3'd0;
        av_chipselect  = 1'b0;
        av_write_n     = 1'b1;
        av_writedata   = 16'h0000;
`ifdef TIMER_DRV_READBACK_EN
        rb_lo_d        = rb_lo_q;
        err_d          = err_q;
`endif

        if (cfg_stop && in_prog) begin
            stop_pending_d = 1'b1;
        end

        case (state_q)
            S_IDLE: begin
                if (cfg_start) begin
                    period_d = cfg_period;
                    state_d  = S_WR_PL;
                end
            end
            S_WR_PL: begin
                av_address    = 3'd2;
                av_chipselect = 1'b1;
                av_write_n    = 1'b0;
                av_writedata  = period_q[15:0];
                state_d       = S_WR_PH;
            end
            S_WR_PH: begin
                av_address    = 3'd3;
                av_chipselect = 1'b1;
                av_write_n    = 1'b0;
                av_writedata  = period_q[31:16];
`ifdef TIMER_DRV_READBACK_EN
                state_d       = S_RD_PL;
`else
                state_d       = S_WR_CTRL;
`endif
            end
`ifdef TIMER_DRV_READBACK_EN
            S_RD_PL: begin
                av_address    = 3'd2;
                av_chipselect = 1'b1;
                state_d       = S_RD_PH;
            end
            S_RD_PH: begin
                // Readdata now carries the low half addressed in RD_PL
                av_address    = 3'd3;
                av_chipselect = 1'b1;
                rb_lo_d       = av_readdata;
                state_d       = S_RD_CHK;
            end
            S_RD_CHK: begin
                if ({av_readdata, rb_lo_q} == period_q) begin
                    state_d = S_WR_CTRL;
                end else begin
                    // Abort: the timer holds a bad period, never start it
                    err_d          = 1'b1;
                    stop_pending_d = 1'b0;
                    state_d        = S_IDLE;
                end
            end
`endif
            S_WR_CTRL: begin
                av_address    = 3'd1;
                av_chipselect = 1'b1;
                av_write_n    = 1'b0;
                av_writedata  = CTRL_RUN;
                state_d       = S_RUN;
            end
            S_RUN: begin
                // Stop wins over a simultaneous interrupt
                if (cfg_stop || stop_pending_q) begin
                    stop_pending_d = 1'b0;
                    state_d        = S_STOP_CTRL;
                end else if (av_irq) begin
                    state_d = S_CLR_STS;
                end
            end
            S_CLR_STS: begin
                av_address    = 3'd0;
                av_chipselect = 1'b1;
                av_write_n    = 1'b0;
                tick_count_d  = tick_count_q + {{(TICK_W-1){1'b0}}, 1'b1};
                state_d       = S_RUN;
            end
            S_STOP_CTRL: begin
                av_address    = 3'd1;
                av_chipselect = 1'b1;
                av_write_n    = 1'b0;
                av_writedata  = CTRL_STOP;
                state_d       = S_STOP_STS;
            end
            S_STOP_STS: begin
                av_address    = 3'd0;
                av_chipselect = 1'b1;
                av_write_n    = 1'b0;
                state_d       = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= S_IDLE;
            period_q       <= 32'h0;
            stop_pending_q <= 1'b0;
            tick_count_q   <= '0;
`ifdef TIMER_DRV_READBACK_EN
            rb_lo_q        <= 16'h0;
            err_q          <= 1'b0;
`endif
        end else begin
            state_q        <= state_d;
            period_q       <= period_d;
            stop_pending_q <= stop_pending_d;
            tick_count_q   <= tick_count_d;
`ifdef TIMER_DRV_READBACK_EN
            rb_lo_q        <= rb_lo_d;
            err_q          <= err_d;
`endif
        end
    end

    assign tick       = (state_q == S_CLR_STS);
    assign tick_count = tick_count_q;
    assign running    = (state_q == S_RUN);
    assign busy       = (state_q != S_IDLE) && (state_q != S_RUN);
`ifdef TIMER_DRV_READBACK_EN
    assign err        = err_q;
`else
    assign err        = 1'b0;
`endif

endmodule
